ring_arb: RTL and testbench



---
 rtl/ring_arb_pkg.sv | 29 ++
 rtl/ring_arb_if.sv | 29 ++
 rtl/ring_arb_rr_pick.sv | 32 +++
 rtl/ring_arb.sv | 133 +++++++++++++
 tb/tb_ring_arb.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ring_arb_pkg.sv
// Shared bridge definitions for the port ring plus the ring_arb state encoding.
// The one-hot arbiter state bits live here so the bridge can decode them directly.
package ring_arb_pkg;

  localparam int NUM_PORTS = 4;

  localparam int PRW_PVEC     = 70;
  localparam int PRW_PCC_MSB  = 69;
  localparam int PRW_PCC_LSB  = 68;

  typedef logic [1:0] pcc_t;
  localparam pcc_t PCC_EOP    = 2'b10;
  localparam pcc_t PCC_BADEOP = 2'b11;

  localparam int s_idle  = 0;
  localparam int s_grant = 1;
  localparam int s_busy  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'(1 << s_idle),
    GRANT = 3'(1 << s_grant),
    BUSY  = 3'(1 << s_busy)
  } arb_state_e;

  function automatic int rrNext(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ring_arb_if.sv
// Handshake and ring-monitor bundle between the port ring taps and ring_arb.
// slave = arbiter side, master = tap/monitor side.
interface ring_arb_if
  import ring_arb_pkg::*;
#(
  parameter int num_ports = NUM_PORTS
);
  localparam int OW = (num_ports > 1) ? $clog2(num_ports) : 1;

  logic [num_ports-1:0] rarb_req;
  logic [num_ports-1:0] rarb_ack;
  logic [num_ports-1:0] rmon_xfer;
  logic [num_ports-1:0] rmon_pvec;
  logic [num_ports-1:0] rmon_eop;
  logic [OW-1:0]        arb_owner;
  logic                 arb_busy;
  logic                 arb_err;

  modport slave (
    input  rarb_req, rmon_xfer, rmon_pvec, rmon_eop,
    output rarb_ack, arb_owner, arb_busy, arb_err
  );

  modport master (
    output rarb_req, rmon_xfer, rmon_pvec, rmon_eop,
    input  rarb_ack, arb_owner, arb_busy, arb_err
  );

endinterface

// File: rtl/ring_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module ring_arb_rr_pick
  import ring_arb_pkg::*;
#(
  parameter int num_ports = NUM_PORTS,
  parameter int IW        = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic [num_ports-1:0] req_i,
  input  logic [IW-1:0]        ptr_i,
  output logic [num_ports-1:0] grant_o,
  output logic [IW-1:0]        idx_o,
  output logic                 valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < num_ports; k++) begin
      cand = IW'((int'(ptr_i) + k) % num_ports);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_arb.sv
// Ring injection arbiter: round-robin grant held from owner header to owner EOP.
// Optional owner-silence timeout enabled by RING_ARB_TIMEOUT_EN.
module ring_arb
  import ring_arb_pkg::*;
#(
  parameter int num_ports = NUM_PORTS,
  parameter int timeout   = 1024
) (
  input logic       clk,
  input logic       reset,
  ring_arb_if.slave bus
);

  localparam int OW = (num_ports > 1) ? $clog2(num_ports) : 1;

  if (timeout < 1 || num_ports < 1) begin : gParamCheck
    $error("ring_arb: timeout and num_ports must be positive");
  end

  arb_state_e           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d, ptr_q, ptr_d, ptrNext;
  logic [num_ports-1:0] ack_q, ack_d;
  logic                 err_q, err_d;

  logic [num_ports-1:0] pickGrant, ownerMask;
  logic [OW-1:0]        pickIdx;
  logic                 pickValid;
  logic                 ownXfer, ownHdr, ownEop, ownReq, foreignHdr, expired;

  ring_arb_rr_pick #(.num_ports(num_ports), .IW(OW)) uPick (
    .req_i   (bus.rarb_req),
    .ptr_i   (ptr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  // In IDLE nobody owns the ring, so every header counts as a violation.
  always_comb begin
    ownerMask = '0;
    if (state_q != IDLE) ownerMask[owner_q] = 1'b1;
  end

  assign ownXfer    = bus.rmon_xfer[owner_q];
  assign ownHdr     = ownXfer & bus.rmon_pvec[owner_q];
  assign ownEop     = ownXfer & ~bus.rmon_pvec[owner_q] & bus.rmon_eop[owner_q];
  assign ownReq     = bus.rarb_req[owner_q];
  assign foreignHdr = |(bus.rmon_xfer & bus.rmon_pvec & ~ownerMask);
  assign ptrNext    = OW'(rrNext(int'(owner_q), num_ports));

`ifdef RING_ARB_TIMEOUT_EN
  localparam int TW = $clog2(timeout + 1);
  logic [TW-1:0] tmr_q, tmr_d;

  // Counts cycles without owner progress; expiry fires on the timeout-th one.
  always_comb begin
    tmr_d   = '0;
    expired = 1'b0;
    if ((state_q == GRANT && ownReq && !ownHdr) || (state_q == BUSY && !ownXfer)) begin
      if (tmr_q == TW'(timeout - 1)) expired = 1'b1;
      else                           tmr_d   = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    ack_d   = ack_q;
    err_d   = foreignHdr | expired;
    unique case (state_q)
      IDLE: begin
        ack_d = '0;
        if (pickValid) begin
          owner_d = pickIdx;
          ack_d   = pickGrant;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ownHdr) begin
          ack_d   = '0;
          state_d = BUSY;
        end else if (!ownReq || expired) begin
          ack_d   = '0;
          ptr_d   = ptrNext;
          state_d = IDLE;
        end
      end
      BUSY: begin
        ack_d = '0;
        if (ownEop || expired) begin
          ptr_d   = ptrNext;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.rarb_ack  = ack_q;
  assign bus.arb_owner = owner_q;
  assign bus.arb_busy  = (state_q == BUSY);
  assign bus.arb_err   = err_q;

endmodule

// File: tb/tb_ring_arb.sv
// Directed bench for ring_arb with four ports and timeout=8.
// Covers both builds of RING_ARB_TIMEOUT_EN.
module tb_ring_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nCompared = 0;
  int   nMismatched = 0;

  ring_arb_if #(.num_ports(4)) bus ();

  ring_arb #(.num_ports(4), .timeout(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] xfer,
                               input logic [3:0] pvec, input logic [3:0] eop);
    bus.rarb_req  = req;
    bus.rmon_xfer = xfer;
    bus.rmon_pvec = pvec;
    bus.rmon_eop  = eop;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expectOut(input string tag, input logic [3:0] ack,
                           input logic busy, input logic err);
    checkOutput({tag, ".ack"},  32'(bus.rarb_ack), 32'(ack));
    checkOutput({tag, ".busy"}, 32'(bus.arb_busy), 32'(busy));
    checkOutput({tag, ".err"},  32'(bus.arb_err),  32'(err));
  endtask

  initial begin
    logic [3:0] oh;
    int order [4] = '{0, 1, 3, 0};

    bus.rarb_req  = '0;
    bus.rmon_xfer = '0;
    bus.rmon_pvec = '0;
    bus.rmon_eop  = '0;
    tick();
    tick();
    expectOut("reset", 4'b0000, 1'b0, 1'b0);
    checkOutput("reset.owner", 32'(bus.arb_owner), 0);
    reset = 1'b0;

    // single request on port 2
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    expectOut("single.grant", 4'b0100, 1'b0, 1'b0);
    checkOutput("single.owner", 32'(bus.arb_owner), 2);
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    expectOut("single.hdr", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000);
    expectOut("single.data", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0100, 4'b0000, 4'b0100);
    expectOut("single.eop", 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    expectOut("single.ptr3", 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("single.drop", 4'b0000, 1'b0, 1'b0);

    // contention, 3-word packets, requests held on 0, 1, 3
    foreach (order[i]) begin
      oh = 4'b0001 << order[i];
      applyStimulus(4'b1011, 4'b0000, 4'b0000, 4'b0000);
      expectOut($sformatf("cont%0d.grant", i), oh, 1'b0, 1'b0);
      checkOutput($sformatf("cont%0d.owner", i), 32'(bus.arb_owner), 32'(order[i]));
      applyStimulus(4'b1011, oh, oh, 4'b0000);
      expectOut($sformatf("cont%0d.hdr", i), 4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b1011, oh, 4'b0000, 4'b0000);
      expectOut($sformatf("cont%0d.data", i), 4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b1011, oh, 4'b0000, oh);
      expectOut($sformatf("cont%0d.bubble", i), 4'b0000, 1'b0, 1'b0);
    end

    // abort: port 1 drops its request without sending a header
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    expectOut("abort.grant", 4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("abort.idle", 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    expectOut("abort.ptr2", 4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // violation: port 3 header while port 0 owns the ring
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expectOut("viol.grant", 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    expectOut("viol.hdr", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b1000, 4'b1000, 4'b0000);
    expectOut("viol.pulse", 4'b0000, 1'b1, 1'b1);
    checkOutput("viol.owner", 32'(bus.arb_owner), 0);
    applyStimulus(4'b0001, 4'b0010, 4'b0000, 4'b0000);
    expectOut("viol.fwd", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, 4'b0001);
    expectOut("viol.eop", 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0100, 4'b0100, 4'b0000);
    expectOut("viol.idlehdr", 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("viol.clear", 4'b0000, 1'b0, 1'b0);

    // owner goes silent in BUSY
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    expectOut("tmo.grant", 4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    expectOut("tmo.hdr", 4'b0000, 1'b1, 1'b0);
`ifdef RING_ARB_TIMEOUT_EN
    repeat (7) applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("tmo.wait7", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("tmo.expire", 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("tmo.after", 4'b0000, 1'b0, 1'b0);
`else
    repeat (100) applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("tmo.hold100", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0100, 4'b0000, 4'b0100);
    expectOut("tmo.eop", 4'b0000, 1'b0, 1'b0);
`endif

    // reset mid-packet, with a stray header that must not leave err set
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    expectOut("rst.grant", 4'b1000, 1'b0, 1'b0);
    checkOutput("rst.owner3", 32'(bus.arb_owner), 3);
    applyStimulus(4'b1000, 4'b1000, 4'b1000, 4'b0000);
    expectOut("rst.hdr", 4'b0000, 1'b1, 1'b0);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0100, 4'b0100, 4'b0000);
    expectOut("rst.mid", 4'b0000, 1'b0, 1'b0);
    checkOutput("rst.owner0", 32'(bus.arb_owner), 0);
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    expectOut("rst.ptr0", 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    expectOut("rst.regrant", 4'b0010, 1'b0, 1'b0);
    checkOutput("rst.owner1", 32'(bus.arb_owner), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
